// File: rtl/ahb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_arb_pkg
// Shared definitions for the 5-master AHB bus arbiter:
//   - AHB HTRANS / HBURST encodings
//   - arbiter FSM state type
//   - burst_beats(): number of beats of a fixed-length burst type
// One-hot master vectors everywhere use bit4=M1, bit3=M2, bit2=M3,
// bit1=M4, bit0=M5.
// ---------------------------------------------------------------------------
package ahb_arb_pkg;

    localparam int NUM_MST = 5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_INCR,
        ST_LOCK
    } arb_state_t;

    // Undefined-length INCR has no fixed beat count and returns 0.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            HBURST_SINGLE:               beats = 5'd1;
            HBURST_WRAP4, HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                     beats = 5'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// ---------------------------------------------------------------------------
// ahb_rr_pick
// Combinational rotating-priority picker. The search starts at the master
// after the last winner in order M1 -> M5 (bit4 down to bit0), wrapping,
// and the first requester found wins. With no requester the default master
// is returned.
// Ports:
//   req      in  5  per-master request
//   last_oh  in  5  one-hot previous winner
//   gnt_oh   out 5  one-hot winner (DEF_MST_OH when req == 0)
// ---------------------------------------------------------------------------
module ahb_rr_pick
    import ahb_arb_pkg::*;
#(
    parameter logic [NUM_MST-1:0] DEF_MST_OH = 5'b00001
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [NUM_MST-1:0] last_oh,
    output logic [NUM_MST-1:0] gnt_oh
);

    logic [2:0] last_idx;
    logic [2:0] idx;
    logic       found;

    // Bit index of the previous winner.
    always_comb begin
        last_idx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (last_oh[i]) begin
                last_idx = 3'(i);
            end
        end
    end

    // Walk downward in bit index from the previous winner (M1 -> M5 order),
    // wrapping after bit0; the previous winner itself is checked last.
    always_comb begin
        gnt_oh = DEF_MST_OH;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_MST; k++) begin
            idx = 3'((int'(last_idx) + NUM_MST - k) % NUM_MST);
            if (!found && req[idx]) begin
                gnt_oh      = '0;
                gnt_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter
// Round-robin arbiter for the shared AHB address/control bus of 5 masters.
// Fixed-length bursts are never broken, locked sequences run to completion,
// and undefined-length INCR bursts yield when the owner stops requesting or
// after INCR_MAX_BEATS beats when someone else is waiting. M5 is the default
// master.
// Ports:
//   HCLK       in   1  bus clock, rising edge
//   HRESETn    in   1  asynchronous active-low reset
//   HBUSREQ    in   5  per-master bus request
//   HLOCK      in   5  per-master lock request
//   HTRANS     in   2  current address-phase transfer type (from addr_mux)
//   HBURST     in   3  current burst type (from addr_mux)
//   HREADY     in   1  transfer done from selected slave
//   HGRANT     out  5  one-hot grant to masters
//   addr_sel   out  5  one-hot address-phase owner, drives addr_mux
//   data_sel   out  5  one-hot data-phase owner (addr_sel delayed a beat)
//   HMASTLOCK  out  1  current address phase belongs to a locked sequence
// ---------------------------------------------------------------------------
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter logic [NUM_MST-1:0] DEF_MST_OH     = 5'b00001,
    parameter int                 INCR_MAX_BEATS = 16
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NUM_MST-1:0] HBUSREQ,
    input  logic [NUM_MST-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    output logic [NUM_MST-1:0] HGRANT,
    output logic [NUM_MST-1:0] addr_sel,
    output logic [NUM_MST-1:0] data_sel,
    output logic               HMASTLOCK
);

    localparam int               CNT_W     = (INCR_MAX_BEATS > 16) ? $clog2(INCR_MAX_BEATS) : 4;
    localparam logic [CNT_W-1:0] INCR_LAST = CNT_W'(INCR_MAX_BEATS - 1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    arb_state_t         start_state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   start_cnt;
    logic [NUM_MST-1:0] rr_last;
    logic [NUM_MST-1:0] pick_oh;
    logic               start_arb;
    logic               arb_evt;
    logic               arb_pt;
    logic               owner_req;
    logic               owner_lock;
    logic               others_req;
    logic               nonseq_acc;
    logic               seq_acc;
    logic               idle_acc;
    logic               beat_acc;
    logic               handover_done;

    ahb_rr_pick #(
        .DEF_MST_OH(DEF_MST_OH)
    ) u_rr_pick (
        .req    (HBUSREQ),
        .last_oh(rr_last),
        .gnt_oh (pick_oh)
    );

    // The address-phase owner is whoever addr_sel currently points at.
    assign owner_req  = |(HBUSREQ & addr_sel);
    assign owner_lock = |(HLOCK & addr_sel);
    assign others_req = |(HBUSREQ & ~addr_sel);

    assign nonseq_acc = HREADY && (HTRANS == HTRANS_NONSEQ);
    assign seq_acc    = HREADY && (HTRANS == HTRANS_SEQ);
    assign idle_acc   = HREADY && (HTRANS == HTRANS_IDLE);
    assign beat_acc   = nonseq_acc || seq_acc;

    // While a new grant has not yet reached addr_sel, the incoming master is
    // guaranteed its one address phase, so no re-arbitration happens then.
    // Grant changes are also held off during wait states.
    assign handover_done = (HGRANT == addr_sel);
    assign arb_pt        = arb_evt && HREADY && handover_done;

    // What an accepted NONSEQ starts: a locked sequence, an open-ended INCR,
    // a SINGLE (which is already its own last beat), or a fixed burst whose
    // remaining beat count is loaded into the counter.
    always_comb begin
        start_state = ST_BURST;
        start_cnt   = CNT_W'(burst_beats(HBURST) - 5'd1);
        start_arb   = 1'b0;
        if (owner_lock) begin
            start_state = ST_LOCK;
            start_cnt   = '0;
        end else if (HBURST == HBURST_INCR) begin
            start_state = ST_INCR;
            start_cnt   = CNT_W'(1);
        end else if (HBURST == HBURST_SINGLE) begin
            start_state = ST_IDLE;
            start_cnt   = '0;
            start_arb   = 1'b1;
        end
    end

    // Next-state and arbitration-point decision. Every transition is
    // qualified by HREADY, so wait states freeze state and beat_cnt.
    // An IDLE transfer inside a burst is taken as the burst ending, which
    // keeps an aborted burst from holding the bus forever.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = beat_cnt;
        arb_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                arb_evt = 1'b1;
                if (nonseq_acc) begin
                    state_nxt = start_state;
                    cnt_nxt   = start_cnt;
                    arb_evt   = start_arb;
                end
            end
            ST_BURST: begin
                if (nonseq_acc) begin
                    state_nxt = start_state;
                    cnt_nxt   = start_cnt;
                    arb_evt   = start_arb;
                end else if (seq_acc) begin
                    if (beat_cnt <= CNT_W'(1)) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        arb_evt   = 1'b1;
                    end else begin
                        cnt_nxt = beat_cnt - CNT_W'(1);
                    end
                end else if (idle_acc) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    arb_evt   = 1'b1;
                end
            end
            ST_INCR: begin
                if (nonseq_acc) begin
                    state_nxt = start_state;
                    cnt_nxt   = start_cnt;
                    arb_evt   = start_arb;
                end else if (idle_acc || (HREADY && !owner_req) ||
                             (HREADY && (beat_cnt == INCR_LAST) && others_req)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    arb_evt   = 1'b1;
                end else if (seq_acc && (beat_cnt != INCR_LAST)) begin
                    cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            ST_LOCK: begin
                if (beat_acc && !owner_lock) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    arb_evt   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // All arbiter state and registered outputs. The grant is taken from the
    // picker only at an arbitration point; addr_sel follows HGRANT and
    // data_sel follows addr_sel on every HREADY cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            rr_last   <= DEF_MST_OH;
            HGRANT    <= DEF_MST_OH;
            addr_sel  <= DEF_MST_OH;
            data_sel  <= DEF_MST_OH;
            HMASTLOCK <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= cnt_nxt;
            HMASTLOCK <= (state_nxt == ST_LOCK) && owner_lock;
            if (arb_pt) begin
                HGRANT  <= pick_oh;
                rr_last <= pick_oh;
            end
            if (HREADY) begin
                addr_sel <= HGRANT;
                data_sel <= addr_sel;
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_bus_arbiter
// Self-checking bench for ahb_bus_arbiter. Cycle vectors (inputs plus the
// outputs expected after the following rising edge) are listed in tables;
// driving a vector pushes its expectation onto a scoreboard queue, which is
// popped and compared one time unit after the edge. A mid-burst reset pulse
// is exercised by a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_ahb_bus_arbiter;
    import ahb_arb_pkg::*;

    localparam logic [4:0] M1 = 5'b10000;
    localparam logic [4:0] M2 = 5'b01000;
    localparam logic [4:0] M3 = 5'b00100;
    localparam logic [4:0] M4 = 5'b00010;
    localparam logic [4:0] M5 = 5'b00001;
    localparam logic [4:0] NO = 5'b00000;

    localparam logic [1:0] TI = HTRANS_IDLE;
    localparam logic [1:0] TN = HTRANS_NONSEQ;
    localparam logic [1:0] TS = HTRANS_SEQ;
    localparam logic [2:0] BS = HBURST_SINGLE;
    localparam logic [2:0] BI = HBURST_INCR;
    localparam logic [2:0] B4 = HBURST_INCR4;
    localparam logic [2:0] B8 = HBURST_INCR8;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [4:0] HBUSREQ;
    logic [4:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [4:0] HGRANT;
    logic [4:0] addr_sel;
    logic [4:0] data_sel;
    logic       HMASTLOCK;

    typedef struct {
        string      name;
        logic [4:0] req;
        logic [4:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        logic [4:0] e_gnt;
        logic [4:0] e_addr;
        logic [4:0] e_data;
        logic       e_mlock;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] gnt;
        logic [4:0] addr;
        logic [4:0] data;
        logic       mlock;
    } exp_t;

    vec_t vecs[$];
    vec_t vecs_pre_rst[$];
    vec_t vecs_post_rst[$];
    exp_t exp_q[$];
    int   pass_count = 0;
    int   check_count = 0;

    always #5 HCLK = ~HCLK;

    ahb_bus_arbiter dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .addr_sel (addr_sel),
        .data_sel (data_sel),
        .HMASTLOCK(HMASTLOCK)
    );

    function automatic vec_t mk(input string n, input logic [4:0] req, input logic [4:0] lock,
                                input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                                input logic [4:0] g, input logic [4:0] a, input logic [4:0] d,
                                input logic ml);
        vec_t v;
        v.name = n; v.req = req; v.lock = lock; v.trans = tr; v.burst = bu; v.ready = rdy;
        v.e_gnt = g; v.e_addr = a; v.e_data = d; v.e_mlock = ml;
        return v;
    endfunction

    task automatic pushExpect(input string n, input logic [4:0] g, input logic [4:0] a,
                              input logic [4:0] d, input logic ml);
        exp_t e;
        e.name = n; e.gnt = g; e.addr = a; e.data = d; e.mlock = ml;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        HBUSREQ = v.req;
        HLOCK   = v.lock;
        HTRANS  = v.trans;
        HBURST  = v.burst;
        HREADY  = v.ready;
        pushExpect(v.name, v.e_gnt, v.e_addr, v.e_data, v.e_mlock);
    endtask

    task automatic checkOutput();
        exp_t e;
        check_count++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: no expectation queued at %0t", $time);
            return;
        end
        e = exp_q.pop_front();
        if (HGRANT === e.gnt && addr_sel === e.addr && data_sel === e.data && HMASTLOCK === e.mlock) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got HGRANT=%b addr_sel=%b data_sel=%b HMASTLOCK=%b, expected HGRANT=%b addr_sel=%b data_sel=%b HMASTLOCK=%b",
                     e.name, HGRANT, addr_sel, data_sel, HMASTLOCK, e.gnt, e.addr, e.data, e.mlock);
        end
    endtask

    task automatic runCycle(input vec_t v);
        applyStimulus(v);
        @(posedge HCLK);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, required under 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset / idle / single-master handover
        vecs.push_back(mk("t1_idle",        NO, NO, TI, BS, 1, M5, M5, M5, 0));
        vecs.push_back(mk("t2_grant",       M2, NO, TI, BS, 1, M2, M5, M5, 0));
        vecs.push_back(mk("t2_addr",        M2, NO, TI, BS, 1, M2, M2, M5, 0));
        vecs.push_back(mk("t2_data",        M2, NO, TI, BS, 1, M2, M2, M2, 0));
        vecs.push_back(mk("t2_release",     NO, NO, TI, BS, 1, M5, M2, M2, 0));
        vecs.push_back(mk("t2_rel_addr",    NO, NO, TI, BS, 1, M5, M5, M2, 0));
        vecs.push_back(mk("t2_rel_data",    NO, NO, TI, BS, 1, M5, M5, M5, 0));
        // Round robin between M1 and M3
        vecs.push_back(mk("t3_m1_first",    M1|M3, NO, TI, BS, 1, M1, M5, M5, 0));
        vecs.push_back(mk("t3_m1_addr",     M1|M3, NO, TI, BS, 1, M1, M1, M5, 0));
        vecs.push_back(mk("t3_m1_single",   M1|M3, NO, TN, BS, 1, M3, M1, M1, 0));
        vecs.push_back(mk("t3_m3_addr",     M3, NO, TI, BS, 1, M3, M3, M1, 0));
        vecs.push_back(mk("t3_m3_hold",     M3, NO, TI, BS, 1, M3, M3, M3, 0));
        vecs.push_back(mk("t3_m1_alone",    M1, NO, TI, BS, 1, M1, M3, M3, 0));
        vecs.push_back(mk("t3_m1_addr2",    M1|M3, NO, TI, BS, 1, M1, M1, M3, 0));
        vecs.push_back(mk("t3_m3_next",     M1|M3, NO, TI, BS, 1, M3, M1, M1, 0));
        vecs.push_back(mk("t3_drop_ho",     NO, NO, TI, BS, 1, M3, M3, M1, 0));
        vecs.push_back(mk("t3_to_default",  NO, NO, TI, BS, 1, M5, M3, M3, 0));
        vecs.push_back(mk("t3_def_addr",    NO, NO, TI, BS, 1, M5, M5, M3, 0));
        vecs.push_back(mk("t3_def_data",    NO, NO, TI, BS, 1, M5, M5, M5, 0));
        // INCR4 with wait states, M4 waiting throughout
        vecs.push_back(mk("t4_grant_m2",    M2|M4, NO, TI, BS, 1, M2, M5, M5, 0));
        vecs.push_back(mk("t4_addr_m2",     M2|M4, NO, TI, BS, 1, M2, M2, M5, 0));
        vecs.push_back(mk("t4_beat1",       M2|M4, NO, TN, B4, 1, M2, M2, M2, 0));
        vecs.push_back(mk("t4_wait1",       M2|M4, NO, TS, B4, 0, M2, M2, M2, 0));
        vecs.push_back(mk("t4_wait2",       M2|M4, NO, TS, B4, 0, M2, M2, M2, 0));
        vecs.push_back(mk("t4_beat2",       M2|M4, NO, TS, B4, 1, M2, M2, M2, 0));
        vecs.push_back(mk("t4_beat3",       M2|M4, NO, TS, B4, 1, M2, M2, M2, 0));
        vecs.push_back(mk("t4_beat4",       M4, NO, TS, B4, 1, M4, M2, M2, 0));
        vecs.push_back(mk("t4_m4_addr",     M4, NO, TI, BS, 1, M4, M4, M2, 0));
        vecs.push_back(mk("t4_m4_hold",     M4, NO, TI, BS, 1, M4, M4, M4, 0));
        vecs.push_back(mk("t4_to_default",  NO, NO, TI, BS, 1, M5, M4, M4, 0));
        vecs.push_back(mk("t4_def_addr",    NO, NO, TI, BS, 1, M5, M5, M4, 0));
        vecs.push_back(mk("t4_def_data",    NO, NO, TI, BS, 1, M5, M5, M5, 0));
        // Undefined-length INCR ends when the owner drops its request
        vecs.push_back(mk("ti_grant_m2",    M2|M4, NO, TI, BS, 1, M2, M5, M5, 0));
        vecs.push_back(mk("ti_addr_m2",     M2|M4, NO, TI, BS, 1, M2, M2, M5, 0));
        vecs.push_back(mk("ti_beat1",       M2|M4, NO, TN, BI, 1, M2, M2, M2, 0));
        vecs.push_back(mk("ti_beat2",       M2|M4, NO, TS, BI, 1, M2, M2, M2, 0));
        vecs.push_back(mk("ti_owner_drop",  M4, NO, TS, BI, 1, M4, M2, M2, 0));
        vecs.push_back(mk("ti_m4_addr",     M4, NO, TI, BS, 1, M4, M4, M2, 0));
        vecs.push_back(mk("ti_to_default",  NO, NO, TI, BS, 1, M5, M4, M4, 0));
        vecs.push_back(mk("ti_def_addr",    NO, NO, TI, BS, 1, M5, M5, M4, 0));
        vecs.push_back(mk("ti_def_data",    NO, NO, TI, BS, 1, M5, M5, M5, 0));
        // Locked sequence of three SINGLEs by M3, M1 waiting
        vecs.push_back(mk("t5_grant_m3",    M3, M3, TI, BS, 1, M3, M5, M5, 0));
        vecs.push_back(mk("t5_addr_m3",     M3, M3, TI, BS, 1, M3, M3, M5, 0));
        vecs.push_back(mk("t5_lock1",       M1|M3, M3, TN, BS, 1, M3, M3, M3, 1));
        vecs.push_back(mk("t5_lock2",       M1|M3, M3, TN, BS, 1, M3, M3, M3, 1));
        vecs.push_back(mk("t5_lock3",       M1|M3, M3, TN, BS, 1, M3, M3, M3, 1));
        vecs.push_back(mk("t5_unlock_idle", M1|M3, NO, TI, BS, 1, M3, M3, M3, 0));
        vecs.push_back(mk("t5_unlock_beat", M1|M3, NO, TN, BS, 1, M1, M3, M3, 0));
        vecs.push_back(mk("t5_m1_addr",     M1, NO, TI, BS, 1, M1, M1, M3, 0));
        vecs.push_back(mk("t5_to_default",  NO, NO, TI, BS, 1, M5, M1, M1, 0));
        vecs.push_back(mk("t5_def_addr",    NO, NO, TI, BS, 1, M5, M5, M1, 0));
        vecs.push_back(mk("t5_def_data",    NO, NO, TI, BS, 1, M5, M5, M5, 0));

        // INCR8 by M2 up to beat 5, M4 waiting, before the reset pulse
        vecs_pre_rst.push_back(mk("t6_grant_m2", M2|M4, NO, TI, BS, 1, M2, M5, M5, 0));
        vecs_pre_rst.push_back(mk("t6_addr_m2",  M2|M4, NO, TI, BS, 1, M2, M2, M5, 0));
        vecs_pre_rst.push_back(mk("t6_beat1",    M2|M4, NO, TN, B8, 1, M2, M2, M2, 0));
        vecs_pre_rst.push_back(mk("t6_beat2",    M2|M4, NO, TS, B8, 1, M2, M2, M2, 0));
        vecs_pre_rst.push_back(mk("t6_beat3",    M2|M4, NO, TS, B8, 1, M2, M2, M2, 0));
        vecs_pre_rst.push_back(mk("t6_beat4",    M2|M4, NO, TS, B8, 1, M2, M2, M2, 0));
        vecs_pre_rst.push_back(mk("t6_beat5",    M2|M4, NO, TS, B8, 1, M2, M2, M2, 0));

        // Normal grant after reset release
        vecs_post_rst.push_back(mk("t6_post_grant", M4, NO, TI, BS, 1, M4, M5, M5, 0));
        vecs_post_rst.push_back(mk("t6_post_addr",  M4, NO, TI, BS, 1, M4, M4, M5, 0));
        vecs_post_rst.push_back(mk("t6_post_data",  M4, NO, TI, BS, 1, M4, M4, M4, 0));
        vecs_post_rst.push_back(mk("t6_post_rel",   NO, NO, TI, BS, 1, M5, M4, M4, 0));
        vecs_post_rst.push_back(mk("t6_post_raddr", NO, NO, TI, BS, 1, M5, M5, M4, 0));
        vecs_post_rst.push_back(mk("t6_post_rdata", NO, NO, TI, BS, 1, M5, M5, M5, 0));

        HRESETn = 1'b0;
        HBUSREQ = NO;
        HLOCK   = NO;
        HTRANS  = TI;
        HBURST  = BS;
        HREADY  = 1'b1;
        #12;
        pushExpect("t1_reset", M5, M5, M5, 0);
        checkOutput();
        @(negedge HCLK);
        HRESETn = 1'b1;

        foreach (vecs[i]) begin
            runCycle(vecs[i]);
        end

        foreach (vecs_pre_rst[i]) begin
            runCycle(vecs_pre_rst[i]);
        end

        // Reset asserted in the middle of the INCR8, away from a clock edge
        HTRANS = TS;
        #2;
        HRESETn = 1'b0;
        #1;
        pushExpect("t6_async_reset", M5, M5, M5, 0);
        checkOutput();
        @(posedge HCLK);
        #1;
        pushExpect("t6_reset_held", M5, M5, M5, 0);
        checkOutput();
        @(negedge HCLK);
        HBUSREQ = NO;
        HTRANS  = TI;
        HBURST  = BS;
        HRESETn = 1'b1;

        foreach (vecs_post_rst[i]) begin
            runCycle(vecs_post_rst[i]);
        end

        if (exp_q.size() != 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard_leftover: got %0d queued expectations, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
